// File: rtl/adjust_scheduler_pkg.sv
// Shared types and helpers for adjust_scheduler: FSM states, step direction
// encoding and a constant clog2 used to size channel indices.
package adjust_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_INC = 1'b1;

  // Never returns less than 1 so a 1-channel index still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adjust_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel at
// or after ptr (wrapping), returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int CHANNELS = 3,
  parameter int CW       = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [CW-1:0]       idx
);

  logic [CW:0] cand;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = {1'b0, ptr} + (CW+1)'(k);
      if (cand >= (CW+1)'(CHANNELS)) cand = cand - (CW+1)'(CHANNELS);
      if (!found && req[cand[CW-1:0]]) begin
        found                = 1'b1;
        grant[cand[CW-1:0]]  = 1'b1;
        idx                  = cand[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/adjust_scheduler.sv
// Shares one bounded add/subtract datapath between CHANNELS up/down button pairs.
// Define ADJUST_SCHEDULER_AUTO_REPEAT_EN to add hold-to-repeat per channel.
module adjust_scheduler
  import adjust_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int BITS          = 9,
  parameter int MIN           = 0,
  parameter int MAX           = 359,
  parameter int STEP          = 1,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic                           Clock,
  input  logic                           resetn,
  input  logic [CHANNELS-1:0]            inc,
  input  logic [CHANNELS-1:0]            dec,
  output logic [CHANNELS*(BITS+1)-1:0]   values,
  output logic                           upd_valid,
  output logic [clog2(CHANNELS)-1:0]     upd_ch,
  output logic [CHANNELS-1:0]            pending,
  output logic                           busy
);

  localparam int W  = BITS + 1;
  localparam int WE = W + 1;
  localparam int CW = clog2(CHANNELS);

  if (CHANNELS < 2 || CHANNELS > 8 || MIN < 0 || MIN >= MAX || MAX >= (1 << W) ||
      STEP < 1 || STEP > MAX - MIN || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_config
    $error("adjust_scheduler: illegal parameter combination");
  end

  logic [CHANNELS-1:0] act;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] rep_fire;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] act_prev_reg;
  logic [CHANNELS-1:0] pending_reg, pending_next;
  logic [CHANNELS-1:0] dir_reg, dir_next;
  logic [W-1:0]        value_reg [CHANNELS];

  state_t              state_reg, state_next;
  logic [CW-1:0]       ch_reg, ch_next;
  logic [CW-1:0]       ptr_reg, ptr_next;
  logic [W-1:0]        operand_reg, operand_next;
  logic                op_dir_reg, op_dir_next;
  logic                write_en;
  logic [W-1:0]        result;
  logic [WE-1:0]       op_ext, sum_ext;
  logic                upd_valid_reg;
  logic [CW-1:0]       upd_ch_reg;
  logic [CHANNELS-1:0] grant_oh;
  logic [CW-1:0]       grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign act[gi]  = inc[gi] ^ dec[gi];
      assign rise[gi] = act[gi] & ~act_prev_reg[gi];

`ifdef ADJUST_SCHEDULER_AUTO_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = clog2(RMAX + 1);
      logic [RW-1:0] rep_cnt_reg;
      logic          hold_dir_reg;
      logic          held;

      // The press cycle itself counts as the first held cycle.
      assign held         = act[gi] & act_prev_reg[gi] & (inc[gi] == hold_dir_reg);
      assign rep_fire[gi] = held & (rep_cnt_reg <= RW'(1));

      always_ff @(posedge Clock) begin
        if (resetn) begin
          rep_cnt_reg  <= '0;
          hold_dir_reg <= DIR_DEC;
        end else if (!act[gi]) begin
          rep_cnt_reg  <= '0;
        end else if (!held) begin
          rep_cnt_reg  <= RW'(REPEAT_DELAY - 1);
          hold_dir_reg <= inc[gi];
        end else if (rep_fire[gi]) begin
          rep_cnt_reg  <= RW'(REPEAT_PERIOD);
        end else begin
          rep_cnt_reg  <= rep_cnt_reg - 1'b1;
        end
      end
`else
      assign rep_fire[gi] = 1'b0;
`endif

      // A clear in the same cycle frees the slot, so the new request wins.
      assign accept[gi]       = (rise[gi] | rep_fire[gi]) & (~pending_reg[gi] | clr[gi]);
      assign pending_next[gi] = accept[gi] | (pending_reg[gi] & ~clr[gi]);
      assign dir_next[gi]     = accept[gi] ? inc[gi] : dir_reg[gi];
      assign values[gi*W +: W] = value_reg[gi];
    end
  endgenerate

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_arb (
    .req   (pending_reg),
    .ptr   (ptr_reg),
    .grant (grant_oh),
    .idx   (grant_idx)
  );

  // Bound checks use one extra bit so operand+STEP cannot overflow.
  always_comb begin
    op_ext  = {1'b0, operand_reg};
    sum_ext = op_ext;
    result  = operand_reg;
    if (op_dir_reg == DIR_INC) begin
      sum_ext = op_ext + WE'(STEP);
      if (sum_ext > WE'(MAX)) result = (WRAP != 0) ? W'(MIN) : W'(MAX);
      else                    result = sum_ext[W-1:0];
    end else begin
      sum_ext = op_ext - WE'(STEP);
      if (op_ext < WE'(MIN + STEP)) result = (WRAP != 0) ? W'(MAX) : W'(MIN);
      else                          result = sum_ext[W-1:0];
    end
  end

  always_comb begin
    state_next   = state_reg;
    ch_next      = ch_reg;
    ptr_next     = ptr_reg;
    operand_next = operand_reg;
    op_dir_next  = op_dir_reg;
    clr          = '0;
    write_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          state_next   = CALC;
          ch_next      = grant_idx;
          operand_next = value_reg[grant_idx];
          op_dir_next  = |(grant_oh & dir_reg);
        end
      end
      CALC: begin
        write_en   = 1'b1;
        clr        = CHANNELS'(1) << ch_reg;
        ptr_next   = (ch_reg == CW'(CHANNELS - 1)) ? '0 : ch_reg + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (resetn) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      ptr_reg       <= '0;
      operand_reg   <= '0;
      op_dir_reg    <= DIR_DEC;
      act_prev_reg  <= '0;
      pending_reg   <= '0;
      dir_reg       <= {CHANNELS{DIR_DEC}};
      upd_valid_reg <= 1'b0;
      upd_ch_reg    <= '0;
      for (int k = 0; k < CHANNELS; k++) value_reg[k] <= W'(MIN);
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      ptr_reg       <= ptr_next;
      operand_reg   <= operand_next;
      op_dir_reg    <= op_dir_next;
      act_prev_reg  <= act;
      pending_reg   <= pending_next;
      dir_reg       <= dir_next;
      upd_valid_reg <= write_en;
      if (write_en) begin
        upd_ch_reg         <= ch_reg;
        value_reg[ch_reg]  <= result;
      end
    end
  end

  assign upd_valid = upd_valid_reg;
  assign upd_ch    = upd_ch_reg;
  assign pending   = pending_reg;
  assign busy      = (state_reg == CALC);

endmodule

// File: tb/tb_adjust_scheduler.sv
// Bench for adjust_scheduler: a wrapping and a saturating instance share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_adjust_scheduler;

  localparam int C    = 3;
  localparam int W    = 10;
  localparam int MIN  = 0;
  localparam int MAX  = 359;
  localparam int STEP = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [C-1:0]     inc = '0;
  logic [C-1:0]     dec = '0;
  logic [C*W-1:0]   values_a, values_b;
  logic             uv_a, uv_b;
  logic [1:0]       uch_a, uch_b;
  logic [C-1:0]     pend_a, pend_b;
  logic             busy_a, busy_b;

  int checks   = 0;
  int failures = 0;
  int upd_cnt0 = 0;

  always #5 clk = ~clk;

  adjust_scheduler dut_a (
    .Clock     (clk),
    .resetn    (rst),
    .inc       (inc),
    .dec       (dec),
    .values    (values_a),
    .upd_valid (uv_a),
    .upd_ch    (uch_a),
    .pending   (pend_a),
    .busy      (busy_a)
  );

  adjust_scheduler #(.WRAP(0)) dut_b (
    .Clock     (clk),
    .resetn    (rst),
    .inc       (inc),
    .dec       (dec),
    .values    (values_b),
    .upd_valid (uv_b),
    .upd_ch    (uch_b),
    .pending   (pend_b),
    .busy      (busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = wrapping instance, 1 = saturating instance.
  int m_val [2][C];
  bit m_pend [C];
  bit m_old  [C];
  bit m_clr  [C];
  bit m_dir  [C];
  bit m_prev [C];
  int m_ptr, m_ch, m_uch;
  int m_opnd [2];
  bit m_opdir, m_busy, m_uv, m_act;

  function automatic int step_val(input int v, input bit up, input bit wrap);
    if (up)  return (v + STEP > MAX) ? (wrap ? MIN : MAX) : v + STEP;
    else     return (v < MIN + STEP) ? (wrap ? MAX : MIN) : v - STEP;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        m_val[0][c] = MIN; m_val[1][c] = MIN;
        m_pend[c] = 0; m_dir[c] = 0; m_prev[c] = 0;
      end
      m_ptr = 0; m_ch = 0; m_uch = 0; m_busy = 0; m_uv = 0; m_opdir = 0;
    end else begin
      for (int c = 0; c < C; c++) begin m_old[c] = m_pend[c]; m_clr[c] = 0; end
      if (m_busy) begin
        for (int i = 0; i < 2; i++) m_val[i][m_ch] = step_val(m_opnd[i], m_opdir, i == 0);
        m_pend[m_ch] = 0; m_clr[m_ch] = 1;
        m_uv = 1; m_uch = m_ch; m_ptr = (m_ch + 1) % C; m_busy = 0;
      end else begin
        m_uv = 0;
        for (int k = 0; k < C; k++) begin
          if (!m_busy && m_old[(m_ptr + k) % C]) begin
            m_busy = 1; m_ch = (m_ptr + k) % C; m_opdir = m_dir[m_ch];
            m_opnd[0] = m_val[0][m_ch]; m_opnd[1] = m_val[1][m_ch];
          end
        end
      end
      for (int c = 0; c < C; c++) begin
        m_act = inc[c] ^ dec[c];
        if (m_act && !m_prev[c] && (!m_old[c] || m_clr[c])) begin
          m_pend[c] = 1; m_dir[c] = inc[c];
        end
        m_prev[c] = m_act;
      end
    end
  end

  // Per-cycle compare, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < C; c++) begin
      check("value_a", values_a[c*W +: W], m_val[0][c]);
      check("value_b", values_b[c*W +: W], m_val[1][c]);
      check("pending_a", pend_a[c], m_pend[c]);
      check("pending_b", pend_b[c], m_pend[c]);
    end
    check("busy_a", busy_a, m_busy);
    check("busy_b", busy_b, m_busy);
    check("upd_valid_a", uv_a, m_uv);
    check("upd_valid_b", uv_b, m_uv);
    if (m_uv) begin
      check("upd_ch_a", uch_a, m_uch);
      check("upd_ch_b", uch_b, m_uch);
    end
    if (uv_a) begin
      if (uch_a == 2'd0) upd_cnt0++;
      $display("upd t=%0t ch=%0d wrap_val=%0d sat_val=%0d", $time, uch_a,
               values_a[uch_a*W +: W], values_b[uch_a*W +: W]);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [C-1:0] i_m, input logic [C-1:0] d_m);
    inc = i_m; dec = d_m;
    idle(1);
    inc = '0; dec = '0;
    idle(3);
  endtask

  int cnt_before;

  initial begin
    idle(3);
    rst = 1'b0;
    check("lit_reset_values", values_a, 0);
    check("lit_reset_pending", pend_a, 0);
    check("lit_reset_busy", busy_a, 0);
    check("lit_reset_upd_valid", uv_a, 0);

    // Single press: value visible two edges after the sampling edge.
    inc = 3'b001;
    idle(1);
    inc = '0;
    idle(2);
    check("lit_first_value", values_a[0 +: W], 1);
    check("lit_first_upd_valid", uv_a, 1);
    check("lit_first_upd_ch", uch_a, 0);
    check("lit_first_others", values_a[W +: 2*W], 0);
    idle(2);

    // Bound behaviour on channel 1.
    pulse(3'b000, 3'b010);
    check("lit_dec_wrap", values_a[W +: W], 359);
    check("lit_dec_sat", values_b[W +: W], 0);
    pulse(3'b010, 3'b000);
    check("lit_inc_wrap", values_a[W +: W], 0);
    check("lit_inc_sat", values_b[W +: W], 1);
    pulse(3'b000, 3'b010);
    pulse(3'b000, 3'b010);
    check("lit_sat_at_min", values_b[W +: W], 0);
    check("lit_wrap_358", values_a[W +: W], 358);

    // Drive channel 2 to the top bound and beyond.
    for (int n = 0; n < 360; n++) pulse(3'b100, 3'b000);
    check("lit_sat_at_max", values_b[2*W +: W], 359);
    check("lit_wrap_full_turn", values_a[2*W +: W], 0);

    // Simultaneous edges are all queued.
    inc = 3'b011; dec = 3'b100;
    idle(1);
    inc = '0; dec = '0;
    check("lit_all_pending", pend_a, 3'b111);
    idle(8);
    inc = 3'b101;
    idle(1);
    inc = '0;
    idle(6);

    // Both buttons together is no request.
    inc = 3'b001; dec = 3'b001;
    idle(1);
    check("lit_both_high", pend_a[0], 0);
    idle(2);
    inc = '0; dec = '0;
    idle(2);

    // Holding a button gives a single step.
    cnt_before = upd_cnt0;
    inc = 3'b001;
    idle(200);
    inc = '0;
    idle(4);
    check("lit_hold_one_step", upd_cnt0 - cnt_before, 1);

    // Reset during CALC aborts the write.
    inc = 3'b010;
    idle(1);
    inc = '0;
    idle(1);
    check("lit_busy_in_calc", busy_a, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("lit_abort_upd_valid", uv_a, 0);
    check("lit_abort_values", values_a, 0);
    check("lit_abort_pending", pend_a, 0);

    // Random button activity with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          inc[c] = $urandom_range(0, 1);
          dec[c] = ($urandom_range(0, 4) == 0);
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      idle(1);
    end
    rst = 1'b0; inc = '0; dec = '0;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adjust_scheduler.md
Name: adjust_scheduler

Overview:
- Shares one constrained add/subtract datapath between CHANNELS independent up/down button pairs, e.g. the X/Y/Z rotation axes of the 3D object viewer.
- Detects presses, queues one pending step per channel and grants the datapath round-robin.
- Holds every channel's bounded value in an internal bank and publishes all values plus an update strobe.
- Replaces per-axis step registers with one scheduled datapath.

Parameters:
- CHANNELS, 3, number of requester channels (2..8)
- BITS, 9, MSB index of each value; value width W = BITS+1
- MIN, 0, lowest legal value (>= 0)
- MAX, 359, highest legal value (MIN < MAX < 2^W)
- STEP, 1, increment/decrement amount (1 <= STEP <= MAX-MIN)
- WRAP, 1, 1 = wrap past bounds, 0 = saturate at bounds
- REPEAT_DELAY, 50, hold cycles before first auto-repeat (AUTO_REPEAT_EN only)
- REPEAT_PERIOD, 10, cycles between subsequent auto-repeats (AUTO_REPEAT_EN only)

Ports:
- Clock  in  1  rising-edge clock
- resetn  in  1  reset: synchronous, active-high (1 = reset) despite the name
- inc  in  CHANNELS  per-channel increment request level
- dec  in  CHANNELS  per-channel decrement request level
- values  out  CHANNELS*W  channel i value at [i*W +: W]
- upd_valid  out  1  one-cycle pulse when a value is written
- upd_ch  out  clog2(CHANNELS)  channel written; meaningful only with upd_valid
- pending  out  CHANNELS  per-channel queued-request flags
- busy  out  1  high while the FSM is in CALC

Behaviour:
- Reset, sampled on a Clock edge with resetn=1:
  - every value = MIN
  - pending = 0; upd_valid = 0; upd_ch = 0; busy = 0
  - round-robin pointer = 0
  - press history cleared; FSM = IDLE
- Reset mid-operation aborts any CALC with no write.
- Press detection, per channel:
  - act = inc ^ dec. Both high or both low is no request.
  - Previous act is registered. A rising edge of act sets pending[i] and latches dir[i] (1 = inc).
  - An edge while pending[i] is already 1 is dropped; dir is not changed.
- FSM, two states:
  - IDLE: if any pending bit is set, grant the first set bit at or after ptr (modulo CHANNELS). Latch ch and operand = value[ch], then go to CALC.
  - CALC: compute the result, write value[ch], clear pending[ch], pulse upd_valid with upd_ch = ch, set ptr = ch+1 mod CHANNELS, return to IDLE.
- Throughput and latency:
  - At most one update every 2 cycles.
  - Edge sampled at cycle n → pending at n+1 → grant at n+1 → value and upd_valid visible after edge n+2.
- Arithmetic is done in W+1 bits:
  - inc, if operand+STEP > MAX: result = MIN when WRAP=1, else MAX.
  - dec, if operand < MIN+STEP: result = MAX when WRAP=1, else MIN.
  - Otherwise result = operand ± STEP.
- A new edge on the granted channel during CALC:
  - pending is cleared by the write in that same cycle, so the edge is taken as a new pending request.
  - Set wins over clear.
- Simultaneous edges on several channels are all queued and served in round-robin order. No request is lost.

Optional Feature:
- Macro: ADJUST_SCHEDULER_AUTO_REPEAT_EN.
- Defined:
  - A per-channel hold counter runs while act stays high with the same direction.
  - After REPEAT_DELAY cycles it re-sets pending[i], then again every REPEAT_PERIOD cycles.
  - The counter clears when act drops, the direction flips, or on reset.
  - Repeats that land while pending is already set are dropped.
- Undefined: counters are absent. Exactly one step per press edge.

Decomposition:
- Package adjust_pkg holds:
  - the FSM state enum (IDLE, CALC)
  - direction encoding (DIR_DEC=0, DIR_INC=1)
  - a constant function for clog2
- Sub-module rr_arbiter (CHANNELS):
  - inputs: request vector and pointer
  - outputs: one-hot grant plus encoded index
  - purely combinational, instantiated once

Test Plan:
- Reset then pulse inc[0] for 1 cycle → values[0] = 1 two edges later; upd_valid one cycle with upd_ch = 0; other channels stay 0.
- WRAP=1, value[1] = 359, press inc[1] → 0. Press dec[1] at 0 → 359.
- WRAP=0 rebuild, value[2] = 0, press dec[2] → stays 0 with upd_valid still pulsed. At 359, inc → stays 359.
- Rising edges on inc[0], inc[1] and dec[2] in the same cycle → updates on ch 0, 1, 2 in consecutive 2-cycle slots. Then with ptr = 0, edges on ch 0 and 2 → ch 0 served before ch 2.
- inc[0] and dec[0] both high → no pending. Hold inc[0] high for 200 cycles without the macro → exactly one step. With the macro and defaults → 1 + 1 + floor((200-50)/10) = 17 steps.
- Assert resetn during CALC → no upd_valid; all values = MIN and pending = 0 on the next edge.
